cdb_rr_arbiter: RTL and testbench

// - Parametrised successor to the fixed three-source CDB: merges N_EXU execution-unit result channels onto N_BUS parallel broadcast lanes.
// - Each channel has a 1-entry holding register; up to N_BUS held results are granted per cycle in round-robin order.
// - Sits between the EXUs (ALU/MDU/LSU/...) and the RVS/RFU/ROB snoopers; supports pipeline flush on mispredict.

---
 rtl/cdb_rr_arbiter_pkg.sv | 20 ++
 rtl/cdb_rr_arbiter_if.sv | 34 +++
 rtl/cdb_rr_arbiter_rr_multi_grant.sv | 44 ++++
 rtl/cdb_rr_arbiter.sv | 96 +++++++++
 tb/tb_cdb_rr_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/cdb_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin common data bus arbiter.
// Entry widths are fixed here; the top checks that its width parameters agree.
package cdb_rr_arbiter_pkg;

    localparam int unsigned CDB_TAG_W  = 4;
    localparam int unsigned CDB_ROB_W  = 5;
    localparam int unsigned CDB_DATA_W = 32;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_ROB_W-1:0]  rob_id;
        logic [CDB_DATA_W-1:0] data;
    } cdb_entry_t;

    // Single-step modular wrap, valid for a < 2*n (no divider needed).
    function automatic int unsigned wrap_idx(input int unsigned a, input int unsigned n);
        return (a >= n) ? a - n : a;
    endfunction

endpackage

// File: rtl/cdb_rr_arbiter_if.sv
// Result-channel and broadcast-lane bundle of the CDB arbiter.
// master = arbiter side, slave = execution units / snoopers side.
interface cdb_rr_arbiter_if
    import cdb_rr_arbiter_pkg::*;
#(
    parameter int unsigned N_EXU  = 4,
    parameter int unsigned N_BUS  = 2,
    parameter int unsigned TAG_W  = CDB_TAG_W,
    parameter int unsigned ROB_W  = CDB_ROB_W,
    parameter int unsigned DATA_W = CDB_DATA_W
) ();

    logic                      flush;
    logic [N_EXU-1:0]          exu_valid;
    logic [N_EXU-1:0]          exu_ready;
    logic [N_EXU*TAG_W-1:0]    exu_tag;
    logic [N_EXU*ROB_W-1:0]    exu_rob_id;
    logic [N_EXU*DATA_W-1:0]   exu_data;
    logic [N_BUS-1:0]          cdb_valid;
    logic [N_BUS*TAG_W-1:0]    cdb_tag;
    logic [N_BUS*ROB_W-1:0]    cdb_rob_id;
    logic [N_BUS*DATA_W-1:0]   cdb_data;

    modport master (
        input  flush, exu_valid, exu_tag, exu_rob_id, exu_data,
        output exu_ready, cdb_valid, cdb_tag, cdb_rob_id, cdb_data
    );

    modport slave (
        output flush, exu_valid, exu_tag, exu_rob_id, exu_data,
        input  exu_ready, cdb_valid, cdb_tag, cdb_rob_id, cdb_data
    );

endinterface

// File: rtl/cdb_rr_arbiter_rr_multi_grant.sv
// Combinational multi-grant round-robin: picks the first M held channels
// scanning from ptr (mod N), maps the k-th pick to lane k, returns next ptr.
module rr_multi_grant
    import cdb_rr_arbiter_pkg::*;
#(
    parameter  int unsigned N  = 4,
    parameter  int unsigned M  = 2,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]         held,
    input  logic [PW-1:0]        ptr,
    output logic [N-1:0]         grant,
    output logic [M-1:0]         lane_vld,
    output logic [M-1:0][PW-1:0] lane_idx,
    output logic [PW-1:0]        next_ptr
);

    int unsigned   cnt;
    logic [PW-1:0] idx;

    always_comb begin
        grant    = '0;
        lane_vld = '0;
        lane_idx = '0;
        next_ptr = ptr;
        cnt      = 0;
        idx      = '0;
        for (int unsigned j = 0; j < N; j++) begin
            idx = PW'(wrap_idx(32'(ptr) + j, N));
            if (held[idx] && (cnt < M)) begin
                grant[idx] = 1'b1;
                for (int unsigned k = 0; k < M; k++) begin
                    if (cnt == k) begin
                        lane_vld[k] = 1'b1;
                        lane_idx[k] = idx;
                    end
                end
                next_ptr = PW'(wrap_idx(32'(idx) + 1, N));
                cnt      = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Merges N_EXU result channels (1-entry hold each) onto N_BUS registered
// broadcast lanes in round-robin order, with flush and async active-low reset.
module cdb_rr_arbiter
    import cdb_rr_arbiter_pkg::*;
#(
    parameter int unsigned N_EXU  = 4,
    parameter int unsigned N_BUS  = 2,
    parameter int unsigned TAG_W  = CDB_TAG_W,
    parameter int unsigned ROB_W  = CDB_ROB_W,
    parameter int unsigned DATA_W = CDB_DATA_W
) (
    input logic              clk,
    input logic              rst,
    cdb_rr_arbiter_if.master bus
);

    localparam int unsigned PW = (N_EXU > 1) ? $clog2(N_EXU) : 1;

    if ((N_BUS > N_EXU) || (N_BUS < 1) || (N_EXU < 2)) begin : g_bad_cfg
        $error("cdb_rr_arbiter: need 2 <= N_EXU and 1 <= N_BUS <= N_EXU");
    end
    if ((TAG_W != CDB_TAG_W) || (ROB_W != CDB_ROB_W) || (DATA_W != CDB_DATA_W)) begin : g_bad_width
        $error("cdb_rr_arbiter: entry widths must match cdb_rr_arbiter_pkg");
    end

    logic [N_EXU-1:0]          held;
    logic [N_EXU-1:0]          grant;
    logic [N_EXU-1:0]          ready;
    logic [N_EXU-1:0]          accept;
    cdb_entry_t                ent    [N_EXU];
    cdb_entry_t                in_ent [N_EXU];
    logic [PW-1:0]             rr_ptr;
    logic [PW-1:0]             next_ptr;
    logic [N_BUS-1:0]          lane_vld;
    logic [N_BUS-1:0][PW-1:0]  lane_idx;
    logic [N_BUS-1:0]          cdb_valid_q;
    cdb_entry_t                lane_q [N_BUS];

    rr_multi_grant #(.N(N_EXU), .M(N_BUS)) u_grant (
        .held     (held),
        .ptr      (rr_ptr),
        .grant    (grant),
        .lane_vld (lane_vld),
        .lane_idx (lane_idx),
        .next_ptr (next_ptr)
    );

    // A granted channel frees its slot this cycle, so it may accept again.
    always_comb begin
        ready         = {N_EXU{rst & ~bus.flush}} & (~held | grant);
        accept        = bus.exu_valid & ready;
        bus.exu_ready = ready;
        for (int unsigned i = 0; i < N_EXU; i++) begin
            in_ent[i] = '{tag:    bus.exu_tag[i*TAG_W +: TAG_W],
                          rob_id: bus.exu_rob_id[i*ROB_W +: ROB_W],
                          data:   bus.exu_data[i*DATA_W +: DATA_W]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held        <= '0;
            rr_ptr      <= '0;
            cdb_valid_q <= '0;
            for (int unsigned i = 0; i < N_EXU; i++) ent[i] <= '0;
            for (int unsigned k = 0; k < N_BUS; k++) lane_q[k] <= '0;
        end else if (bus.flush) begin
            held        <= '0;
            cdb_valid_q <= '0;
            for (int unsigned k = 0; k < N_BUS; k++) lane_q[k] <= '0;
        end else begin
            held        <= accept | (held & ~grant);
            rr_ptr      <= next_ptr;
            cdb_valid_q <= lane_vld;
            for (int unsigned i = 0; i < N_EXU; i++) begin
                if (accept[i]) ent[i] <= in_ent[i];
            end
            for (int unsigned k = 0; k < N_BUS; k++) begin
                lane_q[k] <= lane_vld[k] ? ent[lane_idx[k]] : '0;
            end
        end
    end

    always_comb begin
        bus.cdb_valid  = cdb_valid_q;
        bus.cdb_tag    = '0;
        bus.cdb_rob_id = '0;
        bus.cdb_data   = '0;
        for (int unsigned k = 0; k < N_BUS; k++) begin
            bus.cdb_tag[k*TAG_W +: TAG_W]      = lane_q[k].tag;
            bus.cdb_rob_id[k*ROB_W +: ROB_W]   = lane_q[k].rob_id;
            bus.cdb_data[k*DATA_W +: DATA_W]   = lane_q[k].data;
        end
    end

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Randomized scoreboard bench for cdb_rr_arbiter: a queue-based reference
// model predicts each cycle's lanes; a monitor compares the registered outputs.
module tb_cdb_rr_arbiter;
    import cdb_rr_arbiter_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned M  = 2;
    localparam int unsigned TW = CDB_TAG_W;
    localparam int unsigned RW = CDB_ROB_W;
    localparam int unsigned DW = CDB_DATA_W;

    typedef struct packed {
        logic          v;
        logic [TW-1:0] tag;
        logic [RW-1:0] rob;
        logic [DW-1:0] data;
    } lane_t;
    typedef lane_t [M-1:0] lanes_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    cdb_rr_arbiter_if #(.N_EXU(N), .N_BUS(M), .TAG_W(TW), .ROB_W(RW), .DATA_W(DW)) bus ();

    cdb_rr_arbiter #(.N_EXU(N), .N_BUS(M), .TAG_W(TW), .ROB_W(RW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: held slots, stored results, scan pointer.
    bit        m_held [N];
    lane_t     m_ent  [N];
    int        m_ptr = 0;
    int        order[$];
    int        ng;
    logic [N-1:0] m_gr, m_ready;
    lanes_t    m_lanes;
    lanes_t    exp_q[$];
    int        accepted_cnt = 0;
    int        dropped_cnt  = 0;
    int        obs_cnt      = 0;

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (m_held[i]) dropped_cnt++;
                m_held[i] = 1'b0;
            end
            m_ptr = 0;
            check("exu_ready_in_reset", bus.exu_ready, '0);
        end else begin
            order.delete();
            for (int j = 0; j < N; j++) begin
                if (m_held[(m_ptr + j) % N]) order.push_back((m_ptr + j) % N);
            end
            ng   = (order.size() < M) ? order.size() : M;
            m_gr = '0;
            for (int k = 0; k < ng; k++) m_gr[order[k]] = 1'b1;
            for (int i = 0; i < N; i++) m_ready[i] = !bus.flush && (!m_held[i] || m_gr[i]);
            check("exu_ready", bus.exu_ready, m_ready);
            m_lanes = '0;
            if (bus.flush) begin
                for (int i = 0; i < N; i++) begin
                    if (m_held[i]) dropped_cnt++;
                    m_held[i] = 1'b0;
                end
            end else begin
                for (int k = 0; k < ng; k++) begin
                    m_lanes[k]         = m_ent[order[k]];
                    m_held[order[k]]   = 1'b0;
                end
                if (ng > 0) m_ptr = (order[ng-1] + 1) % N;
                for (int i = 0; i < N; i++) begin
                    if (bus.exu_valid[i] && m_ready[i]) begin
                        m_held[i] = 1'b1;
                        m_ent[i]  = '{v:    1'b1,
                                      tag:  bus.exu_tag[i*TW +: TW],
                                      rob:  bus.exu_rob_id[i*RW +: RW],
                                      data: bus.exu_data[i*DW +: DW]};
                        accepted_cnt++;
                    end
                end
            end
            exp_q.push_back(m_lanes);
        end
    end

    // Monitor: registered lanes are stable 2 time units after the rising edge.
    lanes_t mon_act, mon_exp;
    always @(posedge clk) begin
        #2;
        for (int k = 0; k < M; k++) begin
            mon_act[k] = '{v:    bus.cdb_valid[k],
                           tag:  bus.cdb_tag[k*TW +: TW],
                           rob:  bus.cdb_rob_id[k*RW +: RW],
                           data: bus.cdb_data[k*DW +: DW]};
        end
        if (!rst) begin
            while (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                for (int k = 0; k < M; k++) if (mon_exp[k].v) dropped_cnt++;
            end
            mon_exp = '0;
        end else if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
        end else begin
            mon_exp = '0;
        end
        for (int k = 0; k < M; k++) begin
            check($sformatf("cdb_lane%0d", k), mon_act[k], mon_exp[k]);
            if (rst && mon_act[k].v) obs_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            bus.exu_tag[i*TW +: TW]    = TW'($urandom);
            bus.exu_rob_id[i*RW +: RW] = RW'($urandom);
            bus.exu_data[i*DW +: DW]   = $urandom;
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic f);
        tick();
        bus.exu_valid = v;
        bus.flush     = f;
        rand_fields();
    endtask

    task automatic do_reset();
        tick();
        rst           = 1'b0;
        bus.exu_valid = '0;
        bus.flush     = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.exu_valid = '1;
        rand_fields();
        repeat (3) tick();
        rst = 1'b1;
        repeat (4) drive('0, 1'b0);

        // Single result on ch2 with fixed fields
        drive(4'b0100, 1'b0);
        bus.exu_tag[2*TW +: TW]    = 4'd3;
        bus.exu_rob_id[2*RW +: RW] = 5'd7;
        bus.exu_data[2*DW +: DW]   = 32'hDEAD_BEEF;
        repeat (3) drive('0, 1'b0);

        // Reset asserted while results are held and in flight
        drive('1, 1'b0);
        drive('1, 1'b0);
        do_reset();

        // All channels streaming from ptr=0
        repeat (6) drive('1, 1'b0);
        repeat (3) drive('0, 1'b0);

        // ptr to 3 via ch2, then ch3+ch0 held together (wrap-around)
        do_reset();
        drive(4'b0100, 1'b0);
        drive(4'b1001, 1'b0);
        repeat (3) drive('0, 1'b0);

        // ch1,ch2 held, then flush while ch0 offers a result
        drive(4'b0110, 1'b0);
        drive(4'b0001, 1'b1);
        repeat (3) drive('0, 1'b0);

        // Random traffic with occasional flush and reset
        repeat (3000) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            else drive(N'($urandom), ($urandom_range(0, 31) == 0));
        end
        repeat (6) drive('0, 1'b0);
        tick();
        #2;
        check("broadcast_exactly_once", 128'(obs_cnt), 128'(accepted_cnt - dropped_cnt));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
